// File: rtl/frame_seq_detect.sv
// -----------------------------------------------------------------------------
// frame_seq_detect
//
// Serial frame checker. Bits arrive one per data_valid cycle, MSB of the
// pattern first. Each completed frame of FRAME_LEN bits is compared against
// the active pattern, and the result is reported one clock after the last bit:
// - match: one-cycle pulse when the frame equals the active pattern.
// - not_match: one-cycle pulse when the frame differs from it.
//
// A sof arriving part-way through a frame discards that partial frame, pulses
// frame_abort, and restarts the frame with the current bit as bit 0.
//
// A new pattern can be loaded at any time through a shadow register. It only
// becomes active when the next frame starts, so a frame is never checked
// against a pattern that changed mid-frame.
//
// Optional build macro:
//   FSD_ERRCNT_EN - adds err_cnt, a saturating count of not_match pulses.
//
// Parameters:
//   FRAME_LEN  - frame length in bits (2..32).
//   PATTERN    - expected frame after reset.
//   ERR_CNT_W  - width of err_cnt.
//
// Ports:
//   clk, rst    - clock; synchronous active-high reset.
//   data        - serial data bit.
//   data_valid  - data is sampled only when this is high.
//   sof         - start of frame, qualified by data_valid.
//   pat_ld      - load request for a new pattern.
//   pat_in      - the new pattern value.
//   match       - pulse: the completed frame equals the pattern.
//   not_match   - pulse: the completed frame differs from the pattern.
//   frame_abort - pulse: a partial frame was discarded by sof.
//   err_cnt     - saturating mismatch count (FSD_ERRCNT_EN builds only).
// -----------------------------------------------------------------------------
module frame_seq_detect #(
  parameter int unsigned          FRAME_LEN = 6,
  parameter logic [FRAME_LEN-1:0] PATTERN   = 6'b011100,
  parameter int unsigned          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data,
  input  logic                 data_valid,
  input  logic                 sof,
  input  logic                 pat_ld,
  input  logic [FRAME_LEN-1:0] pat_in,
  output logic                 match,
  output logic                 not_match,
  output logic                 frame_abort
`ifdef FSD_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned          IDX_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD
  } state_t;

  state_t                 state_q,       state_d;
  logic [IDX_W-1:0]       idx_q,         idx_d;
  logic [FRAME_LEN-1:0]   active_pat_q,  active_pat_d;
  logic [FRAME_LEN-1:0]   shadow_pat_q,  shadow_pat_d;
  logic                   match_q,       match_d;
  logic                   not_match_q,   not_match_d;
  logic                   frame_abort_q, frame_abort_d;

  logic                   frame_start;
  logic [IDX_W-1:0]       cur_idx;
  logic [FRAME_LEN-1:0]   cmp_pat;
  logic                   frame_ok;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    active_pat_d  = active_pat_q;
    shadow_pat_d  = pat_ld ? pat_in : shadow_pat_q;
    match_d       = 1'b0;
    not_match_d   = 1'b0;
    frame_abort_d = 1'b0;
    frame_start   = 1'b0;
    cur_idx       = idx_q;
    cmp_pat       = active_pat_q;
    frame_ok      = 1'b0;

    // While IDLE, bits are ignored until the first sof.
    if (data_valid && (state_q != IDLE || sof)) begin
      frame_start   = (state_q == IDLE) || sof || (idx_q == '0);
      frame_abort_d = sof && (state_q != IDLE) && (idx_q != '0);
      if (frame_start) begin
        // Bit 0 is checked against the shadow, which becomes active for this
        // frame. A pat_ld arriving in this same cycle only reaches the shadow
        // register, so it applies to the following frame instead.
        cur_idx      = '0;
        cmp_pat      = shadow_pat_q;
        active_pat_d = shadow_pat_q;
      end
      frame_ok = (data == cmp_pat[LAST_IDX - cur_idx]) &&
                 (frame_start || state_q == RUN);
      state_d  = frame_ok ? RUN : DEAD;
      if (cur_idx == LAST_IDX) begin
        // The state is left as RUN/DEAD. Because idx returns to 0, the next
        // valid bit is treated as the first bit of a new frame.
        idx_d       = '0;
        match_d     = frame_ok;
        not_match_d = !frame_ok;
      end else begin
        idx_d = cur_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      active_pat_q  <= PATTERN;
      shadow_pat_q  <= PATTERN;
      match_q       <= 1'b0;
      not_match_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      active_pat_q  <= active_pat_d;
      shadow_pat_q  <= shadow_pat_d;
      match_q       <= match_d;
      not_match_q   <= not_match_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign match       = match_q;
  assign not_match   = not_match_q;
  assign frame_abort = frame_abort_q;

`ifdef FSD_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    err_cnt_d = not_match_d ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_frame_seq_detect.sv
module tb_frame_seq_detect;

  localparam int          FL     = 6;
  localparam int          ERR_W  = 2;
  localparam logic [5:0]  PAT    = 6'b011100;
  localparam int          CNTMAX = (1 << ERR_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data = 1'b0;
  logic       data_valid = 1'b0;
  logic       sof = 1'b0;
  logic       pat_ld = 1'b0;
  logic [5:0] pat_in = '0;
  logic       match, not_match, frame_abort;
`ifdef FSD_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt;
`endif

  frame_seq_detect #(
    .FRAME_LEN (FL),
    .PATTERN   (PAT),
    .ERR_CNT_W (ERR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .data_valid  (data_valid),
    .sof         (sof),
    .pat_ld      (pat_ld),
    .pat_in      (pat_in),
    .match       (match),
    .not_match   (not_match),
    .frame_abort (frame_abort)
`ifdef FSD_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] vec;   // {frame_abort, not_match, match}
    int         cnt;
    longint     due;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state: the frame is collected as a value and compared whole.
  bit         m_started;
  int         m_n;
  logic [5:0] m_acc, m_active, m_shadow;
  int         m_cnt;

  function automatic void push(input logic [2:0] vec);
    ev_t e;
    e.vec = vec;
    e.cnt = m_cnt;
    e.due = cyc + 1;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_started = 0;
    m_n       = 0;
    m_acc     = '0;
    m_active  = PAT;
    m_shadow  = PAT;
    m_cnt     = 0;
  endfunction

  function automatic void model_step(input logic v, input logic s, input logic d,
                                     input logic ld, input logic [5:0] p, input logic r);
    if (r) begin
      model_reset();
      return;
    end
    if (v && (m_started || s)) begin
      if (m_started && s && m_n != 0) push(3'b100);
      if (!m_started || s || m_n == 0) begin
        m_active  = m_shadow;
        m_n       = 0;
        m_acc     = '0;
        m_started = 1;
      end
      m_acc = {m_acc[4:0], d};
      m_n++;
      if (m_n == FL) begin
        if (m_acc == m_active) begin
          push(3'b001);
        end else begin
          if (m_cnt < CNTMAX) m_cnt++;
          push(3'b010);
        end
        m_n = 0;
      end
    end
    if (ld) m_shadow = p;
  endfunction

  // Pattern bit the model expects next (used to bias random data toward matches).
  function automatic logic exp_bit(input logic s);
    if (!m_started || s || m_n == 0) return m_shadow[5];
    return m_active[5 - m_n];
  endfunction

  task automatic drive(input logic v, input logic s, input logic d,
                       input logic ld, input logic [5:0] p, input logic r);
    @(negedge clk);
    data_valid = v;
    sof        = s;
    data       = d;
    pat_ld     = ld;
    pat_in     = p;
    rst        = r;
    model_step(v, s, d, ld, p, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, 0);
  endtask

  task automatic send_frame(input logic [5:0] f, input logic first_sof);
    for (int i = 0; i < FL; i++) drive(1, first_sof && (i == 0), f[5 - i], 0, '0, 0);
  endtask

  // Monitor: pops expected events whenever the DUT pulses an output.
  logic [2:0] got;
  ev_t        e;
  always begin
    @(posedge clk);
    #1;
    got = {frame_abort, not_match, match};
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_pulse cycle=%0d got=none required=%b", e.due, e.vec);
    end
    if (got != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cycle=%0d got=%b required=none", cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (e.vec != got || e.due != cyc) begin
          failures++;
          $display("FAIL pulse cycle=%0d got=%b required=%b at cycle %0d", cyc, got, e.vec, e.due);
        end
`ifdef FSD_ERRCNT_EN
        checks++;
        if (int'(err_cnt) != e.cnt) begin
          failures++;
          $display("FAIL err_cnt cycle=%0d got=%0d required=%0d", cyc, err_cnt, e.cnt);
        end
`endif
      end
    end
  end

  task automatic check_quiet(input string name);
    @(negedge clk);
    checks++;
    if ({frame_abort, not_match, match} != 3'b000) begin
      failures++;
      $display("FAIL %s outputs got=%b required=000", name, {frame_abort, not_match, match});
    end
`ifdef FSD_ERRCNT_EN
    checks++;
    if (err_cnt != '0) begin
      failures++;
      $display("FAIL %s err_cnt got=%0d required=0", name, err_cnt);
    end
`endif
  endtask

  logic       rv, rs, rd, rl, rr;
  logic [5:0] rp;

  initial begin
    model_reset();
    drive(0, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, '0, 0);
    check_quiet("reset_state");

    // Bits before the first sof are ignored.
    send_frame(6'b011100, 0);
    idle(2);

    // Basic match, then a mismatch followed by a match.
    send_frame(6'b011100, 1);
    idle(2);
    send_frame(6'b010100, 0);
    send_frame(6'b011100, 0);
    idle(2);

    // Abort after 3 bits, then a good frame.
    for (int i = 0; i < 3; i++) drive(1, i == 0, 1'b1, 0, '0, 0);
    send_frame(6'b011100, 1);
    idle(2);

    // Pattern load mid-frame applies to the next frame only.
    for (int i = 0; i < FL; i++) drive(1, 0, PAT[5 - i], i == 2, 6'b101010, 0);
    send_frame(6'b101010, 0);
    // A load coinciding with bit 0 applies to the following frame.
    for (int i = 0; i < FL; i++) drive(1, 0, PAT[5 - i] ^ 1'b1, i == 0, PAT, 0);
    send_frame(PAT, 0);
    // Multiple loads within a frame: the last value wins.
    for (int i = 0; i < FL; i++) drive(1, 0, PAT[5 - i], i == 1 || i == 4, (i == 1) ? 6'b111111 : 6'b110011, 0);
    send_frame(6'b110011, 0);
    idle(2);

    // Saturation with five mismatches, then rst mid-frame.
    drive(1, 0, 0, 1, PAT, 0);
    idle(1);
    for (int k = 0; k < 5; k++) send_frame(6'b000000, 0);
    drive(0, 0, 0, 1, 6'b101010, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, PAT[5 - i], 0, '0, 0);
    drive(1, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, '0, 0);
    check_quiet("mid_frame_reset");
    send_frame(PAT, 1);
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 9) == 0);
      rl = ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 1) == 0) ? PAT : 6'($urandom);
      rr = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 5) != 0) ? exp_bit(rs) : 1'($urandom);
      drive(rv, rs, rd, rl, rp, rr);
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_seq_detect.md
FRAME_SEQ_DETECT -- requirements
Module: frame_seq_detect

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 6, frame length in bits (legal 2..32).
REQ-002 SHALL have parameter PATTERN, default 6'b011100, reset-time expected frame, MSB compared first.
REQ-003 SHALL have parameter ERR_CNT_W, default 8, width of mismatch counter.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port data  input  1  serial data bit.
REQ-007 SHALL have port data_valid  input  1  data sampled only when high.
REQ-008 SHALL have port sof  input  1  start-of-frame, qualified by data_valid.
REQ-009 SHALL have port pat_ld  input  1  load request for new pattern.
REQ-010 SHALL have port pat_in  input  FRAME_LEN  new pattern value.
REQ-011 SHALL have port match  output  1  one-cycle pulse, completed frame equals active pattern.
REQ-012 SHALL have port not_match  output  1  one-cycle pulse, completed frame differs.
REQ-013 SHALL have port frame_abort  output  1  one-cycle pulse, partial frame discarded by sof.
REQ-014 SHALL have port err_cnt  output  ERR_CNT_W  saturating count of not_match pulses (FSD_ERRCNT_EN only).

Function
REQ-015 SHALL keep bit index idx, 0..FRAME_LEN-1, advancing only on data_valid cycles; wraps FRAME_LEN-1 -> 0.
REQ-016 SHALL compare each valid bit with active_pat[FRAME_LEN-1-idx].
REQ-017 SHALL implement FSM states: IDLE (waiting first frame), RUN (all bits so far match), DEAD (mismatch seen in current frame).
REQ-018 Transitions: IDLE -> RUN/DEAD on first valid bit (match/mismatch); RUN -> DEAD on mismatching bit; at idx==FRAME_LEN-1 any state -> start of next frame (next bit re-evaluated as first bit).
REQ-019 SHALL leave IDLE only on data_valid && sof; before first sof, bits are ignored.
REQ-020 SHALL pulse match (else not_match) one cycle after the valid bit with idx==FRAME_LEN-1; latency 1 clock; never both high.
REQ-021 SHALL treat data_valid && sof with idx!=0 as abort: pulse frame_abort next cycle, no match/not_match, bit becomes bit 0 of new frame.
REQ-022 SHALL treat sof with idx==0 as normal frame start (no abort).
REQ-023 SHALL hold idx, state, outputs low when data_valid low (pulses still deassert after one cycle).
REQ-024 SHALL capture pat_in into shadow register on pat_ld; shadow copies to active_pat when a new frame starts (bit 0 sampled), never mid-frame.
REQ-025 pat_ld in same cycle as bit 0 of a frame SHALL apply to the following frame, not the current one.
REQ-026 Multiple pat_ld within one frame: last value wins.

Reset
REQ-027 On rst high at a clk edge: state=IDLE, idx=0, active_pat=shadow=PATTERN, match=not_match=frame_abort=0, err_cnt=0.
REQ-028 rst mid-frame SHALL discard the partial frame with no pulse of any output.
REQ-029 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-030 Macro FSD_ERRCNT_EN defined: err_cnt present, increments by 1 per not_match pulse, saturates at 2^ERR_CNT_W-1, cleared only by rst.
REQ-031 FSD_ERRCNT_EN undefined: err_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 Defaults; sof on first bit, bits 0,1,1,1,0,0 on 6 consecutive valid cycles -> match=1 for exactly one cycle after 6th bit, not_match=0.
REQ-033 Defaults; frame 0,1,0,1,0,0 followed by 0,1,1,1,0,0 -> not_match pulse then match pulse; err_cnt=1 (macro on).
REQ-034 Defaults; sof, 3 valid bits, then sof with 0,1,1,1,0,0 -> frame_abort pulse after 4th valid cycle, then match after new frame.
REQ-035 pat_ld with pat_in=6'b101010 during frame 1 (pattern 011100 sent) then 101010 sent -> match for both frames.
REQ-036 ERR_CNT_W=2, 5 mismatching frames -> err_cnt 1,2,3,3,3; rst asserted mid-frame 3 bits in -> no pulse, err_cnt=0, active_pat=011100.
